// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use / ID-branch hazard detection and bubble insertion.
// Optional HAZARD_STATS_EN adds saturating stall and bubble counters.
module id_ex_hazard_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic [DATA_W-1:0]  id_rdata1,
    input  logic [DATA_W-1:0]  id_rdata2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_reg_write,
    input  logic               id_mem_to_reg,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_reg_dst,
    input  logic               id_alu_src,
    input  logic               id_branch,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               ex_flush,
    input  logic               mem_mem_read,
    input  logic [REG_W-1:0]   mem_write_reg,
    output logic               ex_valid,
    output logic [REG_W-1:0]   ex_rs,
    output logic [REG_W-1:0]   ex_rt,
    output logic [REG_W-1:0]   ex_rd,
    output logic [REG_W-1:0]   ex_write_reg,
    output logic [DATA_W-1:0]  ex_rdata1,
    output logic [DATA_W-1:0]  ex_rdata2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic               ex_reg_write,
    output logic               ex_mem_to_reg,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
`ifdef HAZARD_STATS_EN
    output logic [31:0]        stat_stall_cnt,
    output logic [31:0]        stat_bubble_cnt,
`endif
    output logic               pc_write,
    output logic               if_id_write,
    output logic               stall
);

    typedef struct packed {
        logic               valid;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   write_reg;
        logic [DATA_W-1:0]  rdata1;
        logic [DATA_W-1:0]  rdata2;
        logic [DATA_W-1:0]  imm;
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } ex_t;

    ex_t  ex_d, ex_q;
    logic hazard_c;
    logic load_use_c, br_ex_c, br_mem_c, qual_c;

    // $0 is hardwired, so a zero destination never creates a dependency
    function automatic logic reg_hit(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b);
        return (dst != '0) && ((dst == a) || (dst == b));
    endfunction

    always_comb begin
        qual_c     = id_valid & ~ex_flush;
        load_use_c = qual_c & ex_q.mem_read & reg_hit(ex_q.rt, id_rs, id_rt);
        br_ex_c    = qual_c & id_branch & ex_q.reg_write & reg_hit(ex_q.write_reg, id_rs, id_rt);
        br_mem_c   = qual_c & id_branch & mem_mem_read & reg_hit(mem_write_reg, id_rs, id_rt);
        hazard_c   = load_use_c | br_ex_c | br_mem_c;
    end

    assign stall       = hazard_c;
    assign pc_write    = ~hazard_c;
    assign if_id_write = ~hazard_c;

    // Flush, stall and an empty ID slot all load an all-zero bubble
    always_comb begin
        ex_d = '0;
        if (!ex_flush && !hazard_c && id_valid) begin
            ex_d.valid      = 1'b1;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.rd         = id_rd;
            ex_d.write_reg  = id_reg_dst ? id_rd : id_rt;
            ex_d.rdata1     = id_rdata1;
            ex_d.rdata2     = id_rdata2;
            ex_d.imm        = id_imm;
            ex_d.reg_write  = id_reg_write;
            ex_d.mem_to_reg = id_mem_to_reg;
            ex_d.mem_read   = id_mem_read;
            ex_d.mem_write  = id_mem_write;
            ex_d.alu_src    = id_alu_src;
            ex_d.alu_op     = id_alu_op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    assign ex_valid      = ex_q.valid;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_rd         = ex_q.rd;
    assign ex_write_reg  = ex_q.write_reg;
    assign ex_rdata1     = ex_q.rdata1;
    assign ex_rdata2     = ex_q.rdata2;
    assign ex_imm        = ex_q.imm;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_alu_op     = ex_q.alu_op;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] bubble_cnt_d, bubble_cnt_q;

    // Saturating event counters; ID-empty bubbles are not counted
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (hazard_c && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if ((hazard_c || ex_flush) && (bubble_cnt_q != 32'hFFFF_FFFF))
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stat_stall_cnt  = stall_cnt_q;
    assign stat_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: directed pipeline scenarios plus a per-cycle model comparison.
module tb_id_ex_hazard_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic        id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
    logic        id_reg_dst, id_alu_src, id_branch;
    logic [3:0]  id_alu_op;
    logic        ex_flush, mem_mem_read;
    logic [4:0]  mem_write_reg;
    logic        ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_write_reg;
    logic [31:0] ex_rdata1, ex_rdata2, ex_imm;
    logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src;
    logic [3:0]  ex_alu_op;
    logic        pc_write, if_id_write, stall;
`ifdef HAZARD_STATS_EN
    logic [31:0] stat_stall_cnt, stat_bubble_cnt;
    logic [31:0] m_stall_cnt, m_bub_cnt, sv_stall, sv_bub;
`endif

    int   tests = 0;
    int   fails = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    id_ex_hazard_reg dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_branch(id_branch),
        .id_alu_op(id_alu_op), .ex_flush(ex_flush), .mem_mem_read(mem_mem_read),
        .mem_write_reg(mem_write_reg), .ex_valid(ex_valid),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_write_reg(ex_write_reg),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
`ifdef HAZARD_STATS_EN
        .stat_stall_cnt(stat_stall_cnt), .stat_bubble_cnt(stat_bubble_cnt),
`endif
        .pc_write(pc_write), .if_id_write(if_id_write), .stall(stall)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model of the instruction currently sitting in EX
    logic        m_valid, m_regw, m_m2r, m_mr, m_mw, m_as;
    logic [4:0]  m_rs, m_rt, m_rd, m_wr;
    logic [31:0] m_d1, m_d2, m_imm;
    logic [3:0]  m_aluop;

    function automatic logic depends(input logic [4:0] dst, input logic [4:0] a, input logic [4:0] b);
        return (dst != 5'd0) && ((dst == a) || (dst == b));
    endfunction

    function automatic logic model_stall();
        if (!id_valid || ex_flush) return 1'b0;
        if (m_mr && depends(m_rt, id_rs, id_rt)) return 1'b1;
        if (id_branch && m_regw && depends(m_wr, id_rs, id_rt)) return 1'b1;
        if (id_branch && mem_mem_read && depends(mem_write_reg, id_rs, id_rt)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_empty();
        {m_valid, m_regw, m_m2r, m_mr, m_mw, m_as} = '0;
        {m_rs, m_rt, m_rd, m_wr} = '0;
        {m_d1, m_d2, m_imm} = '0;
        m_aluop = '0;
    endtask

    initial model_empty();

    always @(posedge clk) begin : model_update
        logic st;
        st = model_stall();
        if (reset) begin
            model_empty();
`ifdef HAZARD_STATS_EN
            m_stall_cnt = 0;
            m_bub_cnt   = 0;
`endif
        end else begin
`ifdef HAZARD_STATS_EN
            if (st && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
            if ((st || ex_flush) && m_bub_cnt != 32'hFFFF_FFFF) m_bub_cnt = m_bub_cnt + 1;
`endif
            if (id_valid && !ex_flush && !st) begin
                m_valid = 1'b1; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
                m_wr = id_reg_dst ? id_rd : id_rt;
                m_d1 = id_rdata1; m_d2 = id_rdata2; m_imm = id_imm;
                m_regw = id_reg_write; m_m2r = id_mem_to_reg; m_mr = id_mem_read;
                m_mw = id_mem_write; m_as = id_alu_src; m_aluop = id_alu_op;
            end else begin
                model_empty();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",        32'(stall),        32'(model_stall()));
            chk("pc_write",     32'(pc_write),     32'(!model_stall()));
            chk("if_id_write",  32'(if_id_write),  32'(!model_stall()));
            chk("ex_valid",     32'(ex_valid),     32'(m_valid));
            chk("ex_rs",        32'(ex_rs),        32'(m_rs));
            chk("ex_rt",        32'(ex_rt),        32'(m_rt));
            chk("ex_rd",        32'(ex_rd),        32'(m_rd));
            chk("ex_write_reg", 32'(ex_write_reg), 32'(m_wr));
            chk("ex_rdata1",    ex_rdata1,         m_d1);
            chk("ex_rdata2",    ex_rdata2,         m_d2);
            chk("ex_imm",       ex_imm,            m_imm);
            chk("ex_ctrl",      32'({ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src}),
                                32'({m_regw, m_m2r, m_mr, m_mw, m_as}));
            chk("ex_alu_op",    32'(ex_alu_op),    32'(m_aluop));
`ifdef HAZARD_STATS_EN
            chk("stat_stall_cnt",  stat_stall_cnt,  m_stall_cnt);
            chk("stat_bubble_cnt", stat_bubble_cnt, m_bub_cnt);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rdata1 = 0; id_rdata2 = 0; id_imm = 0;
        id_reg_write = 0; id_mem_to_reg = 0; id_mem_read = 0; id_mem_write = 0;
        id_reg_dst = 0; id_alu_src = 0; id_branch = 0; id_alu_op = 0;
        ex_flush = 0; mem_mem_read = 0; mem_write_reg = 0;
    endtask

    task automatic put(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic rdst, input logic regw, input logic ld, input logic br);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_reg_dst = rdst; id_reg_write = regw; id_mem_read = ld; id_mem_to_reg = ld;
        id_mem_write = 0; id_alu_src = ld; id_branch = br; id_alu_op = 4'(rs + rt);
        id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        chk_en = 1;
        step();
        reset = 0;
        #1;
        chk("rst ex_valid", 32'(ex_valid), 32'd0);
        chk("rst pc_write", 32'(pc_write), 32'd1);
        chk("rst stall",    32'(stall),    32'd0);
        chk("rst ex_rdata1", ex_rdata1,    32'd0);

        // Load-use: lw $8 then add $9,$8,$10
        put(5'd4, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        put(5'd8, 5'd10, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu stall",    32'(stall),    32'd1);
        chk("lu pc_write", 32'(pc_write), 32'd0);
        step();
        chk("lu bubble valid", 32'(ex_valid),     32'd0);
        chk("lu bubble regw",  32'(ex_reg_write), 32'd0);
        chk("lu released",     32'(stall),        32'd0);
        step();
        chk("lu add valid", 32'(ex_valid),     32'd1);
        chk("lu add rs",    32'(ex_rs),        32'd8);
        chk("lu add wr",    32'(ex_write_reg), 32'd9);

        // ALU op writing $5 then beq $5,$0: one stall
        put(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        put(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("br_alu stall1", 32'(stall), 32'd1);
        step();
        chk("br_alu stall2", 32'(stall), 32'd0);
        step();
        chk("br_alu enter", 32'(ex_valid), 32'd1);

        // lw $5 then beq $5,$0: two stalls (EX then MEM)
        put(5'd1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        put(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("br_lw stall1", 32'(stall), 32'd1);
        step();
        mem_mem_read = 1; mem_write_reg = 5'd5;
        #1;
        chk("br_lw stall2", 32'(stall),    32'd1);
        chk("br_lw pcw2",   32'(pc_write), 32'd0);
        step();
        mem_mem_read = 0; mem_write_reg = 0;
        #1;
        chk("br_lw stall3", 32'(stall), 32'd0);
        step();
        chk("br_lw enter", 32'(ex_valid), 32'd1);

        // $0 immunity
        put(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        put(5'd0, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("r0 stall", 32'(stall), 32'd0);
        step();
        chk("r0 valid", 32'(ex_valid),     32'd1);
        chk("r0 wr",    32'(ex_write_reg), 32'd3);

        // Flush beats load-use
        put(5'd1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        put(5'd8, 5'd10, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        ex_flush = 1;
        #1;
        chk("fl stall",    32'(stall),    32'd0);
        chk("fl pc_write", 32'(pc_write), 32'd1);
`ifdef HAZARD_STATS_EN
        sv_stall = stat_stall_cnt;
        sv_bub   = stat_bubble_cnt;
`endif
        step();
        ex_flush = 0;
        chk("fl bubble valid", 32'(ex_valid), 32'd0);
        chk("fl bubble rt",    32'(ex_rt),    32'd0);
`ifdef HAZARD_STATS_EN
        chk("fl stat_bub",   stat_bubble_cnt, sv_bub + 32'd1);
        chk("fl stat_stall", stat_stall_cnt,  sv_stall);
`endif

        // Pass-through
        put(5'd1, 5'd2, 5'd17, 1'b1, 1'b1, 1'b0, 1'b0);
        id_rdata1 = 32'hDEADBEEF;
        step();
        chk("pt rdata1", ex_rdata1,          32'hDEADBEEF);
        chk("pt wr",     32'(ex_write_reg),  32'd17);
        chk("pt valid",  32'(ex_valid),      32'd1);

        // Empty ID slot carries no stale control, and never stalls
        put(5'd17, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        id_valid = 0; mem_mem_read = 1; mem_write_reg = 5'd17;
        #1;
        chk("iv0 stall", 32'(stall), 32'd0);
        step();
        chk("iv0 regw",  32'(ex_reg_write), 32'd0);
        chk("iv0 mr",    32'(ex_mem_read),  32'd0);
        chk("iv0 valid", 32'(ex_valid),     32'd0);

        // Mixed traffic on a small register set, checked by the model each cycle
        for (int i = 0; i < 80; i++) begin
            put(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            id_valid      = ($urandom_range(0, 7) != 0);
            id_mem_write  = 1'($urandom);
            ex_flush      = ($urandom_range(0, 7) == 0);
            mem_mem_read  = 1'($urandom);
            mem_write_reg = 5'($urandom_range(0, 3));
            step();
        end

        // Reset mid-stream clears EX
        reset = 1;
        step();
        reset = 0;
        idle();
        #1;
        chk("rst2 valid",    32'(ex_valid), 32'd0);
        chk("rst2 pc_write", 32'(pc_write), 32'd1);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
